// File: rtl/fifo_burst_reader_if.sv
// Control, FIFO read-port and output-stream signals of fifo_burst_reader.
// master: the reader itself; slave: the surrounding logic (FIFO, controller, sink).
interface fifo_burst_reader_if #(
   parameter int WIDTH     = 8,
   parameter int LEN_WIDTH = 8
);
   logic                 start;
   logic [LEN_WIDTH-1:0] burst_len;
   logic                 busy;
   logic                 done;
   logic                 timeout;
   logic [LEN_WIDTH-1:0] xfer_cnt;
   logic                 fifo_empty;
   logic                 fifo_rd_en;
   logic [WIDTH-1:0]     fifo_r_data;
   logic [WIDTH-1:0]     m_data;
   logic                 m_valid;
   logic                 m_ready;

   modport master (
      input  start, burst_len, fifo_empty, fifo_r_data, m_ready,
      output busy, done, timeout, xfer_cnt, fifo_rd_en, m_data, m_valid
   );

   modport slave (
      output start, burst_len, fifo_empty, fifo_r_data, m_ready,
      input  busy, done, timeout, xfer_cnt, fifo_rd_en, m_data, m_valid
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a programmed burst from a FIFO read port onto a valid/ready stream through a
// 2-entry skid buffer. Define READER_TIMEOUT_EN to abort bursts that stall on an empty FIFO.
module fifo_burst_reader #(
   parameter int WIDTH          = 8,
   parameter int LEN_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                 clk,
   input logic                 rst,
   fifo_burst_reader_if.master bus
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] issued_q, issued_d;
   logic [LEN_WIDTH-1:0] xfer_q, xfer_d;
   logic [1:0]           occ_q, occ_d;
   logic                 inflight_q, inflight_d;
   logic [WIDTH-1:0]     head_q, head_d;
   logic [WIDTH-1:0]     tail_q, tail_d;
   logic                 pop;
   logic                 rd_en;
   logic                 stall_hit;
   logic [2:0]           pending;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("fifo_burst_reader: TIMEOUT_CYCLES must be at least 1");
   end

   // Slots committed after this edge: held words plus the one in flight, minus a word
   // leaving this cycle; using m_ready combinationally sustains one word per cycle.
   assign pop     = (occ_q != 2'd0) && bus.m_ready;
   assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_en   = (state_q == READ) && !stall_hit && !bus.fifo_empty &&
                    (issued_q < len_q) && (pending < 3'd2);

`ifdef READER_TIMEOUT_EN
   localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [STALL_W-1:0] stall_q, stall_d;
   logic               tmo_q, tmo_d;

   assign stall_hit = (stall_q == STALL_W'(TIMEOUT_CYCLES));

   always_comb begin
      stall_d = stall_q;
      tmo_d   = tmo_q;
      if (state_q == IDLE && bus.start) begin
         stall_d = '0;
         tmo_d   = 1'b0;
      end else if (state_q == READ) begin
         if (rd_en) stall_d = '0;
         else if (stall_hit) tmo_d = 1'b1;
         else if (issued_q < len_q && bus.fifo_empty) stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         tmo_q   <= 1'b0;
      end else begin
         stall_q <= stall_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.timeout = (state_q == FINISH) && tmo_q;
`else
   assign stall_hit   = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      issued_d   = issued_q + LEN_WIDTH'(rd_en);
      xfer_d     = xfer_q + LEN_WIDTH'(pop);
      occ_d      = occ_q;
      inflight_d = rd_en;
      head_d     = head_q;
      tail_d     = tail_q;

      case ({inflight_q, pop})
         2'b10: begin
            if (occ_q == 2'd0) head_d = bus.fifo_r_data;
            else               tail_d = bus.fifo_r_data;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_d = bus.fifo_r_data;
            end else begin
               head_d = tail_q;
               tail_d = bus.fifo_r_data;
            end
         end
         default: ;
      endcase

      case (state_q)
         IDLE: if (bus.start) begin
            len_d    = bus.burst_len;
            issued_d = '0;
            xfer_d   = '0;
            state_d  = (bus.burst_len == '0) ? FINISH : READ;
         end
         READ:    if (issued_q == len_q || stall_hit) state_d = DRAIN;
         DRAIN:   if (!inflight_q && occ_q == 2'd0) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         issued_q   <= '0;
         xfer_q     <= '0;
         occ_q      <= '0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         xfer_q     <= xfer_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (occ_q != 2'd0);
   assign bus.m_data     = head_q;
   assign bus.busy       = (state_q == READ) || (state_q == DRAIN);
   assign bus.done       = (state_q == FINISH);
   assign bus.xfer_cnt   = xfer_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a FIFO model feeds the read port, a monitor
// records the stream, and a table of bursts plus hand-written sequences check results.
module tb_fifo_burst_reader;
   localparam int WIDTH     = 8;
   localparam int LEN_WIDTH = 8;
`ifdef READER_TIMEOUT_EN
   localparam int EMPTY_GAP = 4;
`else
   localparam int EMPTY_GAP = 10;
`endif

   typedef struct {
      logic [7:0]  len;
      int unsigned preload;
      logic [15:0] ready_pat;
      logic [7:0]  base;
      logic [7:0]  exp_xfer;
      int unsigned exp_pops;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fifo_burst_reader_if #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

   fifo_burst_reader #(
      .WIDTH          (WIDTH),
      .LEN_WIDTH      (LEN_WIDTH),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // FIFO model: registered read data, valid on the edge after the pop.
   logic [WIDTH-1:0] fifo_mem [0:1023];
   logic [9:0]       wr_ptr = '0;
   logic [9:0]       rd_ptr = '0;
   logic [WIDTH-1:0] rdata  = '0;

   assign bus.fifo_empty  = (wr_ptr == rd_ptr);
   assign bus.fifo_r_data = rdata;

   always @(posedge clk) begin
      if (bus.fifo_rd_en && wr_ptr != rd_ptr) begin
         rdata  <= fifo_mem[rd_ptr];
         rd_ptr <= rd_ptr + 10'd1;
      end
   end

   // Stream monitor, sampled on the falling edge.
   logic [WIDTH-1:0] got_mem [0:255];
   int unsigned pops = 0, xfers = 0, dones = 0, touts = 0, both = 0;
   int unsigned rd_empty_viol = 0, stall_viol = 0, occ_viol = 0;
   int unsigned last_xfer_cyc = 0, done_cyc = 0;
   int          out_off = 0;
   logic        prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   logic        mon_rd, mon_x;

   assign mon_rd = bus.fifo_rd_en;
   assign mon_x  = bus.m_valid & bus.m_ready;

   always @(negedge clk) begin
      if (rst) begin
         out_off    <= int'(pops) - int'(xfers);
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stall_viol <= stall_viol + 1;
         if (mon_rd) pops <= pops + 1;
         if (mon_rd && bus.fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
         if (mon_x) begin
            got_mem[xfers[7:0]] <= bus.m_data;
            xfers               <= xfers + 1;
            last_xfer_cyc       <= cyc;
         end
         if (int'(pops) + int'(mon_rd) - int'(xfers) - int'(mon_x) - out_off > 2) occ_viol <= occ_viol + 1;
         if (bus.done) begin
            dones    <= dones + 1;
            done_cyc <= cyc;
         end
         if (bus.timeout) touts <= touts + 1;
         if (bus.done && bus.timeout) both <= both + 1;
         prev_stall <= bus.m_valid && !bus.m_ready;
         prev_data  <= bus.m_data;
      end
   end

   int unsigned checks = 0;
   int unsigned fails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [WIDTH-1:0] d);
      fifo_mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 10'd1;
   endtask

   task automatic flush();
      wr_ptr = rd_ptr;
   endtask

   task automatic start_burst(input logic [LEN_WIDTH-1:0] len);
      bus.burst_len = len;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      bus.burst_len = 8'hEE;
   endtask

   task automatic wait_done(input logic [15:0] pat, input int unsigned d0, input string name);
      int unsigned k;
      k = 0;
      while (dones == d0 && k < 400) begin
         bus.m_ready = pat[k[3:0]];
         tick();
         k++;
      end
      bus.m_ready = 1'b1;
      check({name, "_done_seen"}, 32'(dones != d0), 32'd1);
   endtask

   task automatic check_words(input string name, input int unsigned x0,
                              input logic [7:0] base, input int unsigned n);
      logic [7:0] e;
      for (int unsigned j = 0; j < n; j++) begin
         e = base + 8'(j);
         check($sformatf("%s_word%0d", name, j), 32'(got_mem[8'(x0 + j)]), 32'(e));
      end
   endtask

   initial begin
      vec_t        vecs [7];
      int unsigned x0, p0, d0, t0, b0, k;

      vecs[0] = '{8'd4, 4, 16'hFFFF, 8'h11, 8'd4, 4};
      vecs[1] = '{8'd6, 6, 16'h9999, 8'h20, 8'd6, 6};
      vecs[2] = '{8'd3, 5, 16'h5555, 8'h40, 8'd3, 3};
      vecs[3] = '{8'd1, 1, 16'hFFFF, 8'h7F, 8'd1, 1};
      vecs[4] = '{8'd0, 2, 16'hFFFF, 8'h60, 8'd0, 0};
      vecs[5] = '{8'd8, 8, 16'h0F0F, 8'hF8, 8'd8, 8};
      vecs[6] = '{8'd2, 2, 16'h0001, 8'h33, 8'd2, 2};

      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.burst_len = '0;
      bus.m_ready   = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("rst_busy",     32'(bus.busy),       32'd0);
      check("rst_done",     32'(bus.done),       32'd0);
      check("rst_timeout",  32'(bus.timeout),    32'd0);
      check("rst_xfer_cnt", 32'(bus.xfer_cnt),   32'd0);
      check("rst_rd_en",    32'(bus.fifo_rd_en), 32'd0);
      check("rst_m_valid",  32'(bus.m_valid),    32'd0);
      check("rst_m_data",   32'(bus.m_data),     32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("idle_busy", 32'(bus.busy), 32'd0);

      // Latency: start sampled at edge N, pop during N+1, m_valid after N+2.
      for (int unsigned j = 0; j < 4; j++) push(8'h11 + 8'(j));
      x0 = xfers; p0 = pops; d0 = dones;
      start_burst(8'd4);
      check("lat_busy_n",   32'(bus.busy),       32'd1);
      check("lat_rd_en_n",  32'(bus.fifo_rd_en), 32'd1);
      check("lat_valid_n",  32'(bus.m_valid),    32'd0);
      tick();
      check("lat_valid_n1", 32'(bus.m_valid),    32'd0);
      tick();
      check("lat_valid_n2", 32'(bus.m_valid),    32'd1);
      check("lat_data_n2",  32'(bus.m_data),     32'h11);
      tick();
      check("lat_data_n3",  32'(bus.m_data),     32'h12);
      tick();
      check("lat_data_n4",  32'(bus.m_data),     32'h13);
      tick();
      check("lat_data_n5",  32'(bus.m_data),     32'h14);
      tick();
      check("lat_valid_n6", 32'(bus.m_valid),    32'd0);
      check("lat_done_n6",  32'(bus.done),       32'd0);
      tick();
      check("lat_done_n7",  32'(bus.done),       32'd1);
      check("lat_busy_n7",  32'(bus.busy),       32'd0);
      check("lat_xfer_n7",  32'(bus.xfer_cnt),   32'd4);
      tick();
      check("lat_done_n8",  32'(bus.done),       32'd0);
      check("lat_pops",     32'(pops - p0),      32'd4);
      check("lat_dones",    32'(dones - d0),     32'd1);
      check("lat_done_gap", 32'(done_cyc - last_xfer_cyc), 32'd2);

      for (int unsigned i = 0; i < 7; i++) begin
         for (int unsigned j = 0; j < vecs[i].preload; j++) push(vecs[i].base + 8'(j));
         x0 = xfers; p0 = pops; d0 = dones;
         start_burst(vecs[i].len);
         wait_done(vecs[i].ready_pat, d0, $sformatf("vec%0d", i));
         tick();
         tick();
         check_words($sformatf("vec%0d", i), x0, vecs[i].base, 32'(vecs[i].exp_xfer));
         check($sformatf("vec%0d_xfers", i),    32'(xfers - x0),     32'(vecs[i].exp_xfer));
         check($sformatf("vec%0d_pops", i),     32'(pops - p0),      vecs[i].exp_pops);
         check($sformatf("vec%0d_xfer_cnt", i), 32'(bus.xfer_cnt),   32'(vecs[i].exp_xfer));
         check($sformatf("vec%0d_dones", i),    32'(dones - d0),     32'd1);
         check($sformatf("vec%0d_busy", i),     32'(bus.busy),       32'd0);
         check($sformatf("vec%0d_fifo_left", i), 32'(10'(wr_ptr - rd_ptr)),
               vecs[i].preload - vecs[i].exp_pops);
         flush();
      end

      // Start while busy is ignored; burst_len is already scrambled after capture.
      for (int unsigned j = 0; j < 6; j++) push(8'h30 + 8'(j));
      x0 = xfers; p0 = pops; d0 = dones;
      start_burst(8'd6);
      tick();
      tick();
      bus.start     = 1'b1;
      bus.burst_len = 8'd2;
      tick();
      bus.start     = 1'b0;
      wait_done(16'hFFFF, d0, "busy_start");
      for (int unsigned j = 0; j < 4; j++) tick();
      check_words("busy_start", x0, 8'h30, 6);
      check("busy_start_xfer_cnt", 32'(bus.xfer_cnt), 32'd6);
      check("busy_start_pops",     32'(pops - p0),    32'd6);
      check("busy_start_dones",    32'(dones - d0),   32'd1);
      flush();

      // Empty FIFO mid-burst: the reader waits for late words.
      push(8'h50);
      push(8'h51);
      x0 = xfers; p0 = pops; d0 = dones;
      start_burst(8'd5);
      for (int unsigned j = 0; j < EMPTY_GAP; j++) tick();
      check("empty_wait_xfers", 32'(xfers - x0), 32'd2);
      check("empty_wait_busy",  32'(bus.busy),   32'd1);
      for (int unsigned j = 2; j < 5; j++) push(8'h50 + 8'(j));
      wait_done(16'hFFFF, d0, "empty");
      tick();
      tick();
      check_words("empty", x0, 8'h50, 5);
      check("empty_xfer_cnt", 32'(bus.xfer_cnt), 32'd5);
      check("empty_done_gap", 32'(done_cyc - last_xfer_cyc), 32'd2);
      check("empty_timeout",  32'(touts), 32'd0);
      flush();

      // Asynchronous reset in the middle of an 8-word burst.
      for (int unsigned j = 0; j < 8; j++) push(8'h70 + 8'(j));
      x0 = xfers;
      start_burst(8'd8);
      k = 0;
      while (xfers - x0 < 3 && k < 50) begin
         tick();
         k++;
      end
      check("mid_xfers",     32'(xfers - x0),     32'd3);
      check("mid_valid_pre", 32'(bus.m_valid),    32'd1);
      check("mid_busy_pre",  32'(bus.busy),       32'd1);
      check("mid_rd_en_pre", 32'(bus.fifo_rd_en), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_valid_rst", 32'(bus.m_valid),    32'd0);
      check("mid_busy_rst",  32'(bus.busy),       32'd0);
      check("mid_rd_en_rst", 32'(bus.fifo_rd_en), 32'd0);
      check("mid_xfer_rst",  32'(bus.xfer_cnt),   32'd0);
      check("mid_data_rst",  32'(bus.m_data),     32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      flush();
      push(8'hC0);
      push(8'hC1);
      x0 = xfers; d0 = dones;
      start_burst(8'd2);
      wait_done(16'hFFFF, d0, "post_rst");
      tick();
      tick();
      check_words("post_rst", x0, 8'hC0, 2);
      check("post_rst_xfer_cnt", 32'(bus.xfer_cnt), 32'd2);
      flush();

`ifdef READER_TIMEOUT_EN
      for (int unsigned j = 0; j < 3; j++) push(8'h90 + 8'(j));
      x0 = xfers; p0 = pops; d0 = dones; t0 = touts; b0 = both;
      start_burst(8'd5);
      wait_done(16'hFFFF, d0, "tmo");
      tick();
      tick();
      check_words("tmo", x0, 8'h90, 3);
      check("tmo_xfer_cnt", 32'(bus.xfer_cnt), 32'd3);
      check("tmo_pops",     32'(pops - p0),    32'd3);
      check("tmo_pulses",   32'(touts - t0),   32'd1);
      check("tmo_with_done", 32'(both - b0),   32'd1);
      flush();
`else
      t0 = touts;
      b0 = both;
      check("timeout_tied_low", 32'(t0 + b0), 32'd0);
`endif

      check("rd_en_while_empty", 32'(rd_empty_viol), 32'd0);
      check("data_held_stalled", 32'(stall_viol),    32'd0);
      check("occupancy_le_2",    32'(occ_viol),      32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
